// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns
// (bit6=a .. bit0=g) and the scan-decoder FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3,
    SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B,
    SEG_C, SEG_D, SEG_E, SEG_F
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    COMMIT,
    HOLD
  } state_e;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Exact-match decode of an active-low segment pattern
// into {hit, blank, nibble}.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       hit_o,
  output logic       blank_o,
  output logic [3:0] nib_o
);

  always_comb begin
    hit_o = 1'b0;
    nib_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (pat_i == SEG_LUT[i]) begin
        hit_o = 1'b1;
        nib_o = 4'(i);
      end
    end
  end

  assign blank_o = (pat_i == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 7-segment bus: recovers the
// hex nibble and status of every digit from seg/an samples.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    update
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    RUN_MAX = 8'(STABLE_CNT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
    end
  end

  logic [NUM_DIGITS-1:0] an_hot;
  logic                  qual;
  logic [IW-1:0]         idx_s;

  assign an_hot = ~an_s2_q;
  assign qual   = $onehot(an_hot);

  always_comb begin
    idx_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_hot[i]) idx_s = IW'(i);
    end
  end

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0]    pat_q, pat_d;
  logic [7:0]    run_q, run_d;
  logic          same;

  assign same = qual && (idx_s == idx_q) && (seg_s2_q == pat_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (qual) begin
          state_d = TRACK;
          idx_d   = idx_s;
          pat_d   = seg_s2_q;
          run_d   = 8'd1;
        end
      end
      TRACK: begin
        if (!qual) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (same) begin
          if (run_q != RUN_MAX) run_d = run_q + 8'd1;
          if (run_d == RUN_MAX) state_d = COMMIT;
        end else begin
          idx_d = idx_s;
          pat_d = seg_s2_q;
          run_d = 8'd1;
        end
      end
      COMMIT: state_d = HOLD;
      HOLD: begin
        // a steady digit commits once per anode dwell
        if (!qual) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (!same) begin
          state_d = TRACK;
          idx_d   = idx_s;
          pat_d   = seg_s2_q;
          run_d   = 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '1;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      run_q   <= run_d;
    end
  end

  logic       hit, blk;
  logic [3:0] nib;

  seg7_pattern_lookup u_lookup (
    .pat_i   (pat_q),
    .hit_o   (hit),
    .blank_o (blk),
    .nib_o   (nib)
  );

  logic                    commit;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    update_q;
  logic [TW-1:0]           tmo_q [NUM_DIGITS];
  logic [TW-1:0]           tmo_d [NUM_DIGITS];

  assign commit = (state_q == COMMIT);

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    err_d    = err_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      tmo_d[i] = (tmo_q[i] == TMO_MAX) ? tmo_q[i]
                                       : tmo_q[i] + TW'(1);
      if (tmo_d[i] == TMO_MAX) valid_d[i] = 1'b0;
      // commit overrides a timeout landing on the same cycle
      if (commit && (idx_q == IW'(i))) begin
        tmo_d[i]   = '0;
        valid_d[i] = hit;
        blank_d[i] = blk;
        err_d[i]   = !hit && !blk;
        if (hit) digits_d[4*i +: 4] = nib;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) tmo_q[i] <= '0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      update_q <= commit;
      for (int i = 0; i < NUM_DIGITS; i++) tmo_q[i] <= tmo_d[i];
    end
  end

  assign digits = digits_q;
  assign valid  = valid_q;
  assign blank  = blank_q;
  assign err    = err_q;
  assign update = update_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed seg/an vectors
// push expected commits; a negedge monitor checks each update.
module tb_seg_scan_decoder;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  valid, blank, err;
  logic        update;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .NUM_DIGITS (ND),
    .STABLE_CNT (SC),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg    (seg),
    .an     (an),
    .digits (digits),
    .valid  (valid),
    .blank  (blank),
    .err    (err),
    .update (update)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
    logic [3:0]  v;
    logic [3:0]  vm;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   upd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && update) begin
      upd_cnt++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update: got update at cycle %0d expected none",
                 cyc);
      end else begin
        mx = q.pop_front();
        chk("commit_digits", 32'(digits), 32'(mx.d));
        chk("commit_blank", 32'(blank), 32'(mx.b));
        chk("commit_err", 32'(err), 32'(mx.e));
        chk("commit_valid", 32'(valid & mx.vm), 32'(mx.v));
      end
    end
  end

  task automatic push(input logic [15:0] d,
                      input logic [3:0] b,
                      input logic [3:0] e,
                      input logic [3:0] v,
                      input logic [3:0] vm);
    exp_t x;
    x.d  = d;
    x.b  = b;
    x.e  = e;
    x.v  = v;
    x.vm = vm;
    q.push_back(x);
  endtask

  task automatic drive(input logic [6:0] s,
                       input logic [3:0] a,
                       input int n);
    seg = s;
    an  = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_update(input string name,
                             input int max,
                             output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (update) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL %s: got no update expected one within %0d cycles",
               name, max);
    end
  endtask

  task automatic wait_cyc(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int t0, t1, t2;
    seg = SEG_BLANK;
    an  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("por_digits", 32'(digits), 0);
    chk("por_valid", 32'(valid), 0);
    chk("por_update", 32'(update), 0);

    // reset mid-run
    rst_n = 1'b1;
    push(16'h0003, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
    drive(SEG_3, 4'b1110, 20);
    chk("pre_reset_valid", 32'(valid), 32'b0001);
    rst_n = 1'b0;
    #1;
    chk("rst_digits", 32'(digits), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_update", 32'(update), 0);
    drive(SEG_3, 4'b1110, 2);
    push(16'h0003, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
    rst_n = 1'b1;
    base = cyc;
    wait_update("rst_release", 20, t0);
    checks++;
    if (t0 - base < 2 + SC) begin
      failures++;
      $display("FAIL rst_latency: got %0d expected >= %0d",
               t0 - base, 2 + SC);
    end

    // steady decode
    drive(SEG_3, 4'b1111, 5);
    base = upd_cnt;
    push(16'h0003, 4'b0000, 4'b0000, 4'b0001, 4'b1111);
    drive(SEG_3, 4'b1110, 10);
    chk("steady_updates", upd_cnt - base, 1);
    chk("steady_digit0", 32'(digits[3:0]), 32'h3);
    base = upd_cnt;
    push(16'hD003, 4'b0000, 4'b0000, 4'b1001, 4'b1111);
    drive(SEG_D, 4'b0111, 10);
    chk("d_updates", upd_cnt - base, 1);
    chk("d_digit3", 32'(digits[15:12]), 32'hD);
    chk("d_valid", 32'(valid), 32'b1001);

    // glitch rejection
    base = upd_cnt;
    for (int k = 0; k < 10; k++) begin
      drive(SEG_5, 4'b1101, 2);
      drive(SEG_6, 4'b1101, 2);
    end
    chk("glitch_updates", upd_cnt - base, 0);
    chk("glitch_digit1", 32'(digits[7:4]), 0);

    // blank then error
    push(16'hD003, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    drive(SEG_BLANK, 4'b1011, 10);
    chk("blank_vec", 32'(blank), 32'b0100);
    chk("blank_valid2", 32'(valid[2]), 0);
    push(16'hD003, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
    drive(7'b1010101, 4'b1011, 10);
    chk("err_vec", 32'(err), 32'b0100);
    chk("err_blank2", 32'(blank[2]), 0);
    chk("err_digit2", 32'(digits[11:8]), 0);

    // illegal anodes
    base = upd_cnt;
    drive(SEG_3, 4'b1100, 50);
    chk("an1100_updates", upd_cnt - base, 0);
    chk("an1100_idle", 32'(dut.state_q), 32'(IDLE));
    drive(SEG_3, 4'b1111, 50);
    chk("an1111_updates", upd_cnt - base, 0);
    chk("an1111_idle", 32'(dut.state_q), 32'(IDLE));

    // timeout
    push(16'hD007, 4'b0000, 4'b0100, 4'b0001, 4'b0001);
    seg = SEG_7;
    an  = 4'b1110;
    wait_update("commit7", 20, t0);
    push(16'hD017, 4'b0000, 4'b0100, 4'b0010, 4'b0010);
    seg = SEG_1;
    an  = 4'b1101;
    wait_cyc(t0 + 99);
    chk("valid0_at_99", 32'(valid[0]), 1);
    wait_cyc(t0 + 100);
    chk("valid0_at_100", 32'(valid[0]), 0);
    chk("digit0_held", 32'(digits[3:0]), 32'h7);

    // recommit landing on the timeout cycle
    push(16'hD017, 4'b0000, 4'b0100, 4'b0001, 4'b0001);
    seg = SEG_7;
    an  = 4'b1110;
    wait_update("recommit7", 20, t1);
    push(16'hD017, 4'b0000, 4'b0100, 4'b0010, 4'b0010);
    seg = SEG_1;
    an  = 4'b1101;
    wait_cyc(t1 + 93);
    push(16'hD017, 4'b0000, 4'b0100, 4'b0001, 4'b0001);
    seg = SEG_7;
    an  = 4'b1110;
    wait_update("commit_at_timeout", 20, t2);
    chk("commit_cycle", t2 - t1, 100);
    chk("valid0_commit_wins", 32'(valid[0]), 1);
    wait_cyc(t2 + 1);
    chk("valid0_after", 32'(valid[0]), 1);

    drive(SEG_7, 4'b1111, 5);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
